// File: rtl/fb_pkg.sv
// Shared definitions for the double-buffered frame store: default buffer bases
// and the swap-handshake state encoding.
package fb_pkg;

    localparam int unsigned DEF_ADDR_W   = 32;
    localparam logic [31:0] DEF_FB0_BASE = 32'h1000_0000;
    localparam logic [31:0] DEF_FB1_BASE = 32'h1040_0000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VS,
        ACK,
        HOLD
    } swap_state_t;

endpackage

// File: rtl/fb_swap_responder_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level plus a registered
// one-cycle rising-edge pulse.
module sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    logic [STAGES-1:0] sync_q;
    logic              last_q;

    // Pulse is registered so downstream logic sees a clean flop output;
    // it rises STAGES cycles after the first edge that samples din=1.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
            last_q <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            last_q <= sync_q[STAGES-1];
            pulse  <= sync_q[STAGES-1] & ~last_q;
        end
    end

endmodule

// File: rtl/fb_swap_responder.sv
// Responder side of the swap/swap_ack handshake: defers a buffer swap to the
// next display vblank edge, flips front/back selection and acknowledges once.
module fb_swap_responder
    import fb_pkg::*;
#(
    parameter int unsigned        ADDR_W      = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0]  FB0_BASE    = DEF_FB0_BASE,
    parameter logic [ADDR_W-1:0]  FB1_BASE    = DEF_FB1_BASE,
    parameter int unsigned        SYNC_STAGES = 2,
    parameter int unsigned        CNT_W       = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              swap,
    output logic              swap_ack,
    input  logic              vsync,
    output logic              front_sel,
    output logic [ADDR_W-1:0] front_base,
    output logic [ADDR_W-1:0] back_base,
    output logic              flip,
    output logic              pending,
    output logic [CNT_W-1:0]  frame_count,
    output logic [CNT_W-1:0]  repeat_count
);

    swap_state_t state_q, state_d;
    logic        vs_edge;

    sync_edge #(
        .STAGES(SYNC_STAGES)
    ) u_vsync_edge (
        .clock(clock),
        .reset(reset),
        .din  (vsync),
        .pulse(vs_edge)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (swap && vs_edge)  state_d = ACK;
                else if (swap)        state_d = WAIT_VS;
            end
            WAIT_VS: begin
                // A withdrawn request wins over a coincident vblank edge.
                if (!swap)            state_d = IDLE;
                else if (vs_edge)     state_d = ACK;
            end
            ACK:                      state_d = HOLD;
            HOLD: begin
                if (!swap)            state_d = IDLE;
            end
            default:                  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            swap_ack     <= 1'b0;
            flip         <= 1'b0;
            pending      <= 1'b0;
            front_sel    <= 1'b0;
            frame_count  <= '0;
            repeat_count <= '0;
        end else begin
            state_q  <= state_d;
            swap_ack <= (state_d == ACK);
            flip     <= (state_d == ACK);
            pending  <= (state_d == WAIT_VS);
            if (state_d == ACK) front_sel <= ~front_sel;
            if (vs_edge) begin
                frame_count <= frame_count + CNT_W'(1);
                if (state_d != ACK && repeat_count != '1)
                    repeat_count <= repeat_count + CNT_W'(1);
            end
        end
    end

    assign front_base = front_sel ? FB1_BASE : FB0_BASE;
    assign back_base  = front_sel ? FB0_BASE : FB1_BASE;

endmodule

// File: tb/tb_fb_swap_responder.sv
// Directed and randomized checks of fb_swap_responder against a behavioural
// request/vblank model.
module tb_fb_swap_responder;

    localparam int unsigned S      = 2;
    localparam int unsigned CW     = 6;
    localparam int          MAXC   = (1 << CW) - 1;
    localparam logic [31:0] B0     = 32'h1000_0000;
    localparam logic [31:0] B1     = 32'h1040_0000;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          swap  = 1'b0;
    logic          vsync = 1'b0;
    logic          swap_ack, front_sel, flip, pending;
    logic [31:0]   front_base, back_base;
    logic [CW-1:0] frame_count, repeat_count;

    fb_swap_responder #(
        .SYNC_STAGES(S),
        .CNT_W      (CW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .swap        (swap),
        .swap_ack    (swap_ack),
        .vsync       (vsync),
        .front_sel   (front_sel),
        .front_base  (front_base),
        .back_base   (back_base),
        .flip        (flip),
        .pending     (pending),
        .frame_count (frame_count),
        .repeat_count(repeat_count)
    );

    always #5 clock = ~clock;

    int passes = 0;
    int total  = 0;

    // Model: vsync samples per edge, request bookkeeping, front buffer, counters.
    bit hist [0:S+1];
    bit m_ack, m_served, m_waiting, m_front;
    int m_frame, m_rpt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic void model_step(input bit rst, input bit sw, input bit v);
        bit e, flip_now;
        e = hist[S] & ~hist[S+1];
        if (rst) begin
            m_ack = 0; m_served = 0; m_waiting = 0; m_front = 0;
            m_frame = 0; m_rpt = 0;
            for (int i = 0; i <= S + 1; i++) hist[i] = 0;
            return;
        end
        flip_now = 0;
        if (m_ack) begin
            m_ack = 0;
            m_served = 1;
        end else if (m_served) begin
            if (!sw) m_served = 0;
        end else if (sw && e) begin
            flip_now = 1;
            m_waiting = 0;
        end else begin
            m_waiting = sw;
        end
        if (flip_now) begin
            m_ack = 1;
            m_front = ~m_front;
        end
        if (e) begin
            m_frame = (m_frame + 1) & MAXC;
            if (!flip_now && m_rpt != MAXC) m_rpt++;
        end
        for (int i = S + 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = v;
    endfunction

    task automatic tick();
        @(posedge clock);
        model_step(reset, swap, vsync);
        #1;
        chk("swap_ack",     64'(swap_ack),     64'(m_ack));
        chk("flip",         64'(flip),         64'(m_ack));
        chk("pending",      64'(pending),      64'(m_waiting));
        chk("front_sel",    64'(front_sel),    64'(m_front));
        chk("front_base",   64'(front_base),   m_front ? 64'(B1) : 64'(B0));
        chk("back_base",    64'(back_base),    m_front ? 64'(B0) : 64'(B1));
        chk("frame_count",  64'(frame_count),  64'(m_frame));
        chk("repeat_count", 64'(repeat_count), 64'(m_rpt));
    endtask

    task automatic vs_pulse();
        vsync = 1'b1;
        repeat (3) tick();
        vsync = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        bit acked;
        int hold;

        // Reset state
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_front_base", 64'(front_base), 64'(B0));
        chk("rst_back_base",  64'(back_base),  64'(B1));
        chk("rst_swap_ack",   64'(swap_ack),   64'd0);
        chk("rst_pending",    64'(pending),    64'd0);
        chk("rst_frame",      64'(frame_count), 64'd0);
        chk("rst_repeat",     64'(repeat_count), 64'd0);

        // Request waits for vblank, then flips with fixed latency
        repeat (8) tick();
        swap = 1'b1;
        tick();
        chk("t2_pending", 64'(pending), 64'd1);
        repeat (18) tick();
        vsync = 1'b1;
        repeat (3) tick();
        chk("t2_no_early_ack", 64'(swap_ack), 64'd0);
        tick();
        chk("t2_ack",        64'(swap_ack),   64'd1);
        chk("t2_flip",       64'(flip),       64'd1);
        chk("t2_front_base", 64'(front_base), 64'(B1));
        chk("t2_frame",      64'(frame_count), 64'd1);
        chk("t2_repeat",     64'(repeat_count), 64'd0);
        swap = 1'b0;
        tick();
        chk("t2_ack_one_cycle", 64'(swap_ack), 64'd0);

        // Swap held after ack across another vblank: no second flip
        vsync = 1'b0;
        repeat (3) tick();
        swap = 1'b1;
        vsync = 1'b1;
        repeat (4) tick();
        chk("t3_ack", 64'(swap_ack), 64'd1);
        chk("t3_front_sel", 64'(front_sel), 64'd0);
        vsync = 1'b0;
        repeat (2) tick();
        vsync = 1'b1;
        repeat (4) tick();
        chk("t3_no_reack", 64'(swap_ack), 64'd0);
        chk("t3_still_fb0", 64'(front_sel), 64'd0);
        swap = 1'b0;
        repeat (2) tick();
        swap = 1'b1;
        vsync = 1'b0;
        repeat (2) tick();
        vsync = 1'b1;
        repeat (4) tick();
        chk("t3_reflip", 64'(front_sel), 64'd1);
        swap = 1'b0;
        vsync = 1'b0;
        repeat (3) tick();

        // Swap rising with the vblank edge goes straight to ACK
        vsync = 1'b1;
        repeat (3) tick();
        swap = 1'b1;
        tick();
        chk("t5_direct_ack", 64'(swap_ack), 64'd1);
        chk("t5_no_pending", 64'(pending),  64'd0);
        swap = 1'b0;
        vsync = 1'b0;
        repeat (3) tick();

        // Reset while waiting drops the request
        swap = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        swap = 1'b0;
        vs_pulse();
        chk("t6_front_after_rst", 64'(front_sel), 64'd0);

        // Withdrawn request returns to idle without flipping
        swap = 1'b1;
        repeat (3) tick();
        swap = 1'b0;
        tick();
        vs_pulse();
        chk("t6_withdraw_front", 64'(front_sel), 64'd0);
        chk("t6_withdraw_rpt",   64'(repeat_count), 64'd2);

        // Counter saturation and wrap with no requests
        repeat (70) vs_pulse();
        chk("t4_repeat_sat", 64'(repeat_count), 64'(MAXC));

        // Randomized requester and vblank traffic
        acked = 0;
        hold  = 0;
        for (int i = 0; i < 1500; i++) begin
            if (swap_ack) begin
                acked = 1;
                hold  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
            end
            if (swap && acked) begin
                if (hold == 0) begin
                    swap  = 1'b0;
                    acked = 0;
                end else begin
                    hold--;
                end
            end else if (!swap && $urandom_range(0, 5) == 0) begin
                swap = 1'b1;
            end else if (swap && !acked && $urandom_range(0, 49) == 0) begin
                swap = 1'b0;
            end
            if ($urandom_range(0, 4) == 0) vsync = ~vsync;
            reset = ($urandom_range(0, 299) == 0);
            if (reset) begin
                acked = 0;
                hold  = 0;
            end
            tick();
        end
        reset = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
